// File: rtl/arq_multilink_if.sv
// arq_multilink_if
// Groups everything that passes between the baseband decoders/encoder and the
// per-link ARQ engine, except the clock and the reset.
//   master : decoder/encoder side. It drives the RX header/payload strobes, TX slot
//            requests, flush and link-reset commands, and it receives decisions.
//   slave  : ARQ engine side, with the opposite directions.
// Port summary (engine view):
//   in  link_reset_p/link_reset_lt   reinitialise one link
//   in  rx_hdr_p, rx_lt, rx_type, rx_arqn, rx_seqn, rx_flow, rx_hec_ok
//   in  rx_pyld_p, rx_crc_ok, rx_mic_ok, rx_buf_full[NUM_LINK]
//   in  tx_req_p, tx_lt, tx_has_data
//   in  flush_p, flush_lt, retx_limit
//   out tx_valid, tx_sel, tx_arqn, tx_seqn, tx_flow
//   out rx_accept_p, rx_ignore_p, rx_reject_p, link_stop[NUM_LINK]
//   out retx_fail_p, retx_fail_lt
interface arq_multilink_if #(
  parameter int NUM_LINK = 7,
  parameter int LTW      = 3,
  parameter int RTW      = 4
);
  logic                link_reset_p;
  logic [LTW-1:0]      link_reset_lt;
  logic                rx_hdr_p;
  logic [LTW-1:0]      rx_lt;
  logic [3:0]          rx_type;
  logic                rx_arqn;
  logic                rx_seqn;
  logic                rx_flow;
  logic                rx_hec_ok;
  logic                rx_pyld_p;
  logic                rx_crc_ok;
  logic                rx_mic_ok;
  logic [NUM_LINK-1:0] rx_buf_full;
  logic                tx_req_p;
  logic [LTW-1:0]      tx_lt;
  logic                tx_has_data;
  logic                flush_p;
  logic [LTW-1:0]      flush_lt;
  logic [RTW-1:0]      retx_limit;
  logic                tx_valid;
  logic [1:0]          tx_sel;
  logic                tx_arqn;
  logic                tx_seqn;
  logic                tx_flow;
  logic                rx_accept_p;
  logic                rx_ignore_p;
  logic                rx_reject_p;
  logic [NUM_LINK-1:0] link_stop;
  logic                retx_fail_p;
  logic [LTW-1:0]      retx_fail_lt;

  modport master (
    output link_reset_p, link_reset_lt, rx_hdr_p, rx_lt, rx_type, rx_arqn, rx_seqn,
           rx_flow, rx_hec_ok, rx_pyld_p, rx_crc_ok, rx_mic_ok, rx_buf_full,
           tx_req_p, tx_lt, tx_has_data, flush_p, flush_lt, retx_limit,
    input  tx_valid, tx_sel, tx_arqn, tx_seqn, tx_flow, rx_accept_p, rx_ignore_p,
           rx_reject_p, link_stop, retx_fail_p, retx_fail_lt
  );

  modport slave (
    input  link_reset_p, link_reset_lt, rx_hdr_p, rx_lt, rx_type, rx_arqn, rx_seqn,
           rx_flow, rx_hec_ok, rx_pyld_p, rx_crc_ok, rx_mic_ok, rx_buf_full,
           tx_req_p, tx_lt, tx_has_data, flush_p, flush_lt, retx_limit,
    output tx_valid, tx_sel, tx_arqn, tx_seqn, tx_flow, rx_accept_p, rx_ignore_p,
           rx_reject_p, link_stop, retx_fail_p, retx_fail_lt
  );
endinterface

// File: rtl/arq_multilink.sv
// arq_multilink
// Baseband ARQ/SEQN/FLOW engine for up to NUM_LINK ACL logical transports.
// Link index is LT_ADDR-1. For each link the engine tracks:
//   - the TX sequence bit
//   - RX duplicate filtering (the last accepted SEQN)
//   - the pending ACK
//   - the remote FLOW stop
//   - a pending flush
//   - a bounded retransmit counter
// For every TX slot request it tells the encoder whether to send a new packet,
// the old packet, a zero-length continue, or a null.
// Ports:
//   clk_6M  system clock
//   rstz    synchronous active-low reset
//   io_bus  arq_multilink_if slave modport (see interface for the signal list)
module arq_multilink #(
  parameter int          NUM_LINK   = 7,
  parameter int          LTW        = 3,
  parameter int          RTW        = 4,
  parameter logic [15:0] DATA_TYPES = 16'hCD18
) (
  input logic            clk_6M,
  input logic            rstz,
  arq_multilink_if.slave io_bus
);

  typedef enum logic [1:0] {
    SEL_NEW  = 2'b00,
    SEL_OLD  = 2'b01,
    SEL_ZLC  = 2'b10,
    SEL_NULL = 2'b11
  } txSel_e;

  // An LT_ADDR addresses a tracked link only in the range 1..NUM_LINK.
  function automatic logic isLinkValid(input logic [LTW-1:0] lt);
    return (lt != '0) && (int'(lt) <= NUM_LINK);
  endfunction

  logic [NUM_LINK-1:0] r_seqnTx, r_seqnOld, r_ack, r_waiting, r_flushPend, r_stop;
  logic [NUM_LINK-1:0] w_seqnTx, w_seqnOld, w_ack, w_waiting, w_flushPend, w_stop;
  logic [RTW-1:0]      r_retxCnt [NUM_LINK];
  logic [RTW-1:0]      w_retxCnt [NUM_LINK];

  logic           r_hdrValid, w_hdrValid;
  logic [LTW-1:0] r_hdrLt, w_hdrLt;
  logic [3:0]     r_hdrType, w_hdrType;
  logic           r_hdrSeqn, w_hdrSeqn;

  logic           r_txValid, w_txValid;
  txSel_e         r_txSel, w_txSel;
  logic           r_txArqn, w_txArqn, r_txSeqn, w_txSeqn, r_txFlow, w_txFlow;
  logic           r_accept, w_accept, r_ignore, w_ignore, r_reject, w_reject;
  logic           r_retxFail, w_retxFail;
  logic [LTW-1:0] r_retxFailLt, w_retxFailLt;
  logic           w_limitHit;

  logic [LTW-1:0] w_hdrIdx, w_pyldIdx, w_flushIdx, w_txIdx, w_rstIdx;

  assign w_hdrIdx   = io_bus.rx_lt - LTW'(1);
  assign w_pyldIdx  = r_hdrLt - LTW'(1);
  assign w_flushIdx = io_bus.flush_lt - LTW'(1);
  assign w_txIdx    = io_bus.tx_lt - LTW'(1);
  assign w_rstIdx   = io_bus.link_reset_lt - LTW'(1);

  // Next-state for every link is built up in stages within one cycle:
  //   1. the RX header, then the RX payload;
  //   2. flush, then the TX decision;
  //   3. link reset, which overrides all of the above.
  // Staging lets a TX decision see an ACK or payload result that arrives in the
  // same cycle. It also lets an ACK cancel a flush in that cycle.
  always_comb begin
    w_seqnTx     = r_seqnTx;
    w_seqnOld    = r_seqnOld;
    w_ack        = r_ack;
    w_waiting    = r_waiting;
    w_flushPend  = r_flushPend;
    w_stop       = r_stop;
    w_retxCnt    = r_retxCnt;
    w_hdrValid   = r_hdrValid;
    w_hdrLt      = r_hdrLt;
    w_hdrType    = r_hdrType;
    w_hdrSeqn    = r_hdrSeqn;
    w_txValid    = 1'b0;
    w_txSel      = SEL_NEW;
    w_txArqn     = 1'b0;
    w_txSeqn     = 1'b0;
    w_txFlow     = 1'b0;
    w_accept     = 1'b0;
    w_ignore     = 1'b0;
    w_reject     = 1'b0;
    w_retxFail   = 1'b0;
    w_retxFailLt = '0;
    w_limitHit   = 1'b0;

    // A header with a bad HEC invalidates the latched header, so the payload
    // strobe that follows it is discarded.
    if (io_bus.rx_hdr_p) begin
      w_hdrValid = io_bus.rx_hec_ok;
      if (io_bus.rx_hec_ok) begin
        w_hdrLt   = io_bus.rx_lt;
        w_hdrType = io_bus.rx_type;
        w_hdrSeqn = io_bus.rx_seqn;
        if (isLinkValid(io_bus.rx_lt)) begin
          w_stop[w_hdrIdx] = !io_bus.rx_flow;
          if (w_waiting[w_hdrIdx] && io_bus.rx_arqn) begin
            w_waiting[w_hdrIdx]   = 1'b0;
            w_seqnTx[w_hdrIdx]    = ~w_seqnTx[w_hdrIdx];
            w_retxCnt[w_hdrIdx]   = '0;
            w_flushPend[w_hdrIdx] = 1'b0;
          end
        end
      end
    end

    // Payload verdicts. Data types filter duplicates by SEQN. NULL/POLL are
    // silent. Other non-data types are rejected only when SEQN is new.
    if (io_bus.rx_pyld_p && r_hdrValid && isLinkValid(r_hdrLt)) begin
      if (DATA_TYPES[r_hdrType]) begin
        if (r_hdrSeqn == w_seqnOld[w_pyldIdx]) begin
          w_ignore          = 1'b1;
          w_ack[w_pyldIdx]  = 1'b1;
        end else if (io_bus.rx_crc_ok && io_bus.rx_mic_ok && !io_bus.rx_buf_full[w_pyldIdx]) begin
          w_accept             = 1'b1;
          w_seqnOld[w_pyldIdx] = r_hdrSeqn;
          w_ack[w_pyldIdx]     = 1'b1;
        end else begin
          w_reject          = 1'b1;
          w_ack[w_pyldIdx]  = 1'b0;
        end
      end else if (r_hdrType > 4'd1) begin
        if (r_hdrSeqn != w_seqnOld[w_pyldIdx]) begin
          w_reject          = 1'b1;
          w_ack[w_pyldIdx]  = 1'b0;
        end
      end
    end

    // A flush only matters while an unacknowledged packet is outstanding.
    if (io_bus.flush_p && isLinkValid(io_bus.flush_lt) && w_waiting[w_flushIdx]) begin
      w_flushPend[w_flushIdx] = 1'b1;
    end

    // TX slot decision, highest priority first:
    //   remote stop, then abandon (flush or retransmit limit), then retransmit,
    //   then new data, then null.
    // The pending ACK is sent exactly once.
    if (io_bus.tx_req_p) begin
      w_txValid = 1'b1;
      if (!isLinkValid(io_bus.tx_lt)) begin
        w_txSel  = SEL_NULL;
        w_txSeqn = 1'b1;
        w_txFlow = 1'b1;
      end else begin
        w_txArqn       = w_ack[w_txIdx];
        w_ack[w_txIdx] = 1'b0;
        w_txFlow       = !io_bus.rx_buf_full[w_txIdx];
        w_limitHit     = (io_bus.retx_limit != '0) && (w_retxCnt[w_txIdx] == io_bus.retx_limit);
        if (w_stop[w_txIdx]) begin
          w_txSel  = SEL_NULL;
          w_txSeqn = w_seqnTx[w_txIdx];
        end else if (w_waiting[w_txIdx] && (w_flushPend[w_txIdx] || w_limitHit)) begin
          w_txSel              = SEL_ZLC;
          w_seqnTx[w_txIdx]    = ~w_seqnTx[w_txIdx];
          w_txSeqn             = w_seqnTx[w_txIdx];
          w_retxCnt[w_txIdx]   = '0;
          w_flushPend[w_txIdx] = 1'b0;
          if (w_limitHit) begin
            w_retxFail   = 1'b1;
            w_retxFailLt = io_bus.tx_lt;
          end
        end else if (w_waiting[w_txIdx]) begin
          w_txSel  = SEL_OLD;
          w_txSeqn = w_seqnTx[w_txIdx];
          if (w_retxCnt[w_txIdx] != '1) begin
            w_retxCnt[w_txIdx] = w_retxCnt[w_txIdx] + RTW'(1);
          end
        end else if (io_bus.tx_has_data) begin
          w_txSel            = SEL_NEW;
          w_txSeqn           = w_seqnTx[w_txIdx];
          w_waiting[w_txIdx] = 1'b1;
        end else begin
          w_txSel  = SEL_NULL;
          w_txSeqn = w_seqnTx[w_txIdx];
        end
      end
    end

    // Link reset overrides every other update made to that link in this cycle.
    if (io_bus.link_reset_p && isLinkValid(io_bus.link_reset_lt)) begin
      w_seqnTx[w_rstIdx]    = 1'b1;
      w_seqnOld[w_rstIdx]   = 1'b0;
      w_ack[w_rstIdx]       = 1'b0;
      w_waiting[w_rstIdx]   = 1'b0;
      w_retxCnt[w_rstIdx]   = '0;
      w_flushPend[w_rstIdx] = 1'b0;
      w_stop[w_rstIdx]      = 1'b0;
    end
  end

  // State and output registers. All decision and pulse outputs are registered,
  // so they appear one cycle after the strobe that caused them.
  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      r_seqnTx     <= '1;
      r_seqnOld    <= '0;
      r_ack        <= '0;
      r_waiting    <= '0;
      r_flushPend  <= '0;
      r_stop       <= '0;
      for (int i = 0; i < NUM_LINK; i++) r_retxCnt[i] <= '0;
      r_hdrValid   <= 1'b0;
      r_hdrLt      <= '0;
      r_hdrType    <= '0;
      r_hdrSeqn    <= 1'b0;
      r_txValid    <= 1'b0;
      r_txSel      <= SEL_NEW;
      r_txArqn     <= 1'b0;
      r_txSeqn     <= 1'b0;
      r_txFlow     <= 1'b0;
      r_accept     <= 1'b0;
      r_ignore     <= 1'b0;
      r_reject     <= 1'b0;
      r_retxFail   <= 1'b0;
      r_retxFailLt <= '0;
    end else begin
      r_seqnTx     <= w_seqnTx;
      r_seqnOld    <= w_seqnOld;
      r_ack        <= w_ack;
      r_waiting    <= w_waiting;
      r_flushPend  <= w_flushPend;
      r_stop       <= w_stop;
      r_retxCnt    <= w_retxCnt;
      r_hdrValid   <= w_hdrValid;
      r_hdrLt      <= w_hdrLt;
      r_hdrType    <= w_hdrType;
      r_hdrSeqn    <= w_hdrSeqn;
      r_txValid    <= w_txValid;
      r_txSel      <= w_txSel;
      r_txArqn     <= w_txArqn;
      r_txSeqn     <= w_txSeqn;
      r_txFlow     <= w_txFlow;
      r_accept     <= w_accept;
      r_ignore     <= w_ignore;
      r_reject     <= w_reject;
      r_retxFail   <= w_retxFail;
      r_retxFailLt <= w_retxFailLt;
    end
  end

  assign io_bus.tx_valid     = r_txValid;
  assign io_bus.tx_sel       = r_txSel;
  assign io_bus.tx_arqn      = r_txArqn;
  assign io_bus.tx_seqn      = r_txSeqn;
  assign io_bus.tx_flow      = r_txFlow;
  assign io_bus.rx_accept_p  = r_accept;
  assign io_bus.rx_ignore_p  = r_ignore;
  assign io_bus.rx_reject_p  = r_reject;
  assign io_bus.link_stop    = r_stop;
  assign io_bus.retx_fail_p  = r_retxFail;
  assign io_bus.retx_fail_lt = r_retxFailLt;

endmodule

// File: doc/arq_multilink.md
Name: arq_multilink

Overview:
- Per-link Baseband ARQ/SEQN/FLOW engine (Vol2 Part B 7.6) for up to NUM_LINK ACL logical transports. Replaces the single-link ARQ controller.
- Sits between the header/payload decoders and the packet encoder.
- Tracks per-LT_ADDR TX sequence, RX duplicate filtering, ACK to return, remote FLOW stop, flush, and a bounded retransmit counter.
- Tells the encoder, per TX slot, whether to send new, old, zero-length-continue or null.

Parameters:
NUM_LINK, 7, number of tracked LT_ADDRs (1..7); link index = LT_ADDR-1
LTW, 3, LT_ADDR width
RTW, 4, retransmit counter width
DATA_TYPES, 16'hCD18, bitmask of pktype codes that carry ACL data (bits 3,4,8,10,11,14,15)

Ports:
clk_6M  in  1  system clock
rstz  in  1  reset, synchronous, active-low
link_reset_p  in  1  reinitialise one link
link_reset_lt  in  LTW  link to reinitialise
rx_hdr_p  in  1  header decoded strobe
rx_lt  in  LTW  decoded LT_ADDR
rx_type  in  4  decoded pktype
rx_arqn  in  1  decoded ARQN
rx_seqn  in  1  decoded SEQN
rx_flow  in  1  decoded FLOW
rx_hec_ok  in  1  HEC good, qualifies rx_hdr_p
rx_pyld_p  in  1  payload check complete strobe
rx_crc_ok  in  1  CRC good, qualifies rx_pyld_p
rx_mic_ok  in  1  MIC good, or 1 when encryption is off
rx_buf_full  in  NUM_LINK  per-link RX ACL buffer full
tx_req_p  in  1  encoder requests slot decision
tx_lt  in  LTW  target LT_ADDR
tx_has_data  in  1  new ACL payload queued for tx_lt
flush_p  in  1  host flush command
flush_lt  in  LTW  link to flush
retx_limit  in  RTW  max retransmissions; 0 = unlimited
tx_valid  out  1  decision valid, 1-cycle pulse
tx_sel  out  2  00 new, 01 old, 10 zero-length continue, 11 null
tx_arqn  out  1  ARQN to send
tx_seqn  out  1  SEQN to send
tx_flow  out  1  FLOW to send
rx_accept_p  out  1  payload accepted
rx_ignore_p  out  1  duplicate ignored
rx_reject_p  out  1  payload rejected
link_stop  out  NUM_LINK  remote FLOW=0 per link
retx_fail_p  out  1  retransmit limit hit
retx_fail_lt  out  LTW  link that hit the limit

Behaviour:
- Per-link registers and reset values (rstz=0 or link_reset_p):
  - seqn_tx=1, seqn_old=0, ack=0, waiting=0, retx_cnt=0, flush_pend=0, stop=0.
  - All outputs reset to 0.
  - link_reset_p has priority over every other same-cycle update to that link.
- Valid link: LT in 1..NUM_LINK. LT 0 or >NUM_LINK changes no state; tx_req_p to such an LT yields tx_sel=11, arqn=0, seqn=1, flow=1.
- rx_hdr_p & rx_hec_ok, valid link l:
  - stop[l] <= !rx_flow.
  - If waiting[l] & rx_arqn: waiting<=0, seqn_tx<=~seqn_tx, retx_cnt<=0, flush_pend<=0.
  - Latch lt, type and seqn for the payload phase.
- rx_hdr_p & !rx_hec_ok: no state change, and the next rx_pyld_p is discarded.
- rx_pyld_p (uses latched header): pulse outputs assert exactly 1 cycle later.
  - type in DATA_TYPES, seqn==seqn_old: ignore, ack<=1.
  - type in DATA_TYPES, seqn!=seqn_old, crc & mic & !rx_buf_full[l]: accept, seqn_old<=seqn, ack<=1.
  - type in DATA_TYPES, otherwise: reject, ack<=0.
  - type 0 or 1 (NULL/POLL): no pulse, ack unchanged.
  - Other non-data types: reject only when seqn!=seqn_old, ack<=0.
- flush_p: sets flush_pend[flush_lt] only if waiting; otherwise ignored. An ACK in the same cycle wins, so flush_pend stays 0.
- tx_req_p for link l: tx_valid 1 cycle later. The decision uses register state at that edge, including any rx update committed in the tx_req_p cycle. Priority order:
  1. stop[l]: sel=11; no counter change.
  2. waiting & (flush_pend | (retx_limit!=0 & retx_cnt==retx_limit)): sel=10, seqn_tx toggles before send, waiting stays 1, retx_cnt<=0, flush_pend<=0. Assert retx_fail_p/retx_fail_lt when the limit caused it.
  3. waiting: sel=01, retx_cnt increments, saturating at all-ones.
  4. tx_has_data: sel=00, waiting<=1.
  5. else sel=11.
- Field values with tx_valid:
  - tx_arqn=ack[l]; ack[l]<=0 on the same edge (ACK is sent once).
  - tx_seqn=seqn_tx value used for this packet.
  - tx_flow=!rx_buf_full[l] sampled on the decision edge.
- rx_pyld_p during tx_req_p: both are processed independently.

Test Plan:
- Reset, tx_req_p lt=1 with tx_has_data=1 -> tx_valid, sel=00, seqn=1, arqn=0, flow=1; a second tx_req_p -> sel=01, seqn=1.
- rx_hdr_p lt=1 arqn=1 flow=1 hec_ok, then tx_req_p with data -> sel=00, seqn=0.
- Two DM1 (type 3) payloads on lt=2 with seqn=1 and crc ok -> accept then ignore; both cause the next tx arqn=1; a third tx on lt=2 gives arqn=0.
- retx_limit=2, data sent on lt=3 with no ACK, 4 tx_req_p -> sel 00,01,01,10; retx_fail_p with lt=3 on the 4th; tx_seqn toggles on the 4th.
- rx_flow=0 on lt=1 -> link_stop[0]=1 and tx sel=11 despite pending data; a later flow=1 resumes with sel=01.
- flush_p lt=1 while waiting, then tx_req_p -> sel=10 with toggled seqn. link_reset_p lt=1 mid-waiting -> next tx sel=00, seqn=1.
